assist_seq: RTL and testbench

Sequencer for the desired-drive datapath of the e-bike assist controller. On each sample tick it latches the sensor set and presents it stable to the 4-stage pipelined assist-current datapath. It waits out the pipeline latency, then captures the result and drives the motor target current. The current ramps up under a slew limit and falls immediately. Brake input forces zero current at any time.

---
 rtl/assist_seq.sv | 172 +++++++++++++++++
 tb/tb_assist_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assist_seq.sv
// Desired-drive sequencer: latches sensor operands on a tick, waits out the
// assist-current pipeline, then slews target_curr toward the captured result.
module assist_seq #(
    parameter int unsigned PIPE_LAT  = 4,
    parameter logic [11:0] SLEW_STEP = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        brake_n,
    input  logic [11:0] avg_torque_in,
    input  logic [4:0]  cadence_vec_in,
    input  logic [12:0] incline_in,
    input  logic [1:0]  setting_in,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence_vec,
    output logic [12:0] incline,
    output logic [1:0]  setting,
    input  logic [11:0] dd_target_curr,
    output logic [11:0] target_curr,
    output logic        upd_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SLEW   = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] torque;
        logic [4:0]  cadence;
        logic [12:0] incline;
        logic [1:0]  setting;
    } sample_t;

    localparam logic [3:0] LAT = 4'(PIPE_LAT);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [11:0] cap, cap_d;
    logic [11:0] tgt, tgt_d;
    logic        pend, pend_d;
    logic        upd, upd_d;
    logic        busy_q, busy_d;
    sample_t     ops, ops_d;
    sample_t     shadow, shadow_d;
    sample_t     live;

    logic [12:0] ramp_sum;
    logic [11:0] ramp_val;

    assign live = {avg_torque_in, cadence_vec_in, incline_in, setting_in};

    // 13-bit sum keeps a step near full scale from wrapping past cap.
    assign ramp_sum = {1'b0, tgt} + {1'b0, SLEW_STEP};
    assign ramp_val = (ramp_sum > {1'b0, cap}) ? cap : ramp_sum[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d  = state;
        cnt_d    = cnt;
        cap_d    = cap;
        tgt_d    = tgt;
        pend_d   = pend;
        upd_d    = 1'b0;
        ops_d    = ops;
        shadow_d = shadow;

        if (!brake_n) begin
            tgt_d   = '0;
            cap_d   = '0;
            pend_d  = 1'b0;
            state_d = IDLE;
        end else begin
            // A tick arriving mid-update is parked; the newest one wins.
            if (tick && state != IDLE) begin
                shadow_d = live;
                pend_d   = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        ops_d   = live;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else if (pend) begin
                        ops_d   = shadow;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == LAT) begin
                        cap_d   = dd_target_curr;
                        state_d = SLEW;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end

                SLEW: begin
                    if (tgt > cap) begin
                        tgt_d = cap;
                    end else if (tgt < cap) begin
                        tgt_d = ramp_val;
                    end else begin
                        upd_d = 1'b1;
                        if (pend) begin
                            // Old pend is consumed; a same-cycle tick re-arms it.
                            ops_d   = shadow;
                            pend_d  = tick;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cap    <= '0;
            tgt    <= '0;
            pend   <= 1'b0;
            upd    <= 1'b0;
            busy_q <= 1'b0;
            ops    <= '0;
            shadow <= '0;
        end else begin
            cnt    <= cnt_d;
            cap    <= cap_d;
            tgt    <= tgt_d;
            pend   <= pend_d;
            upd    <= upd_d;
            busy_q <= busy_d;
            ops    <= ops_d;
            shadow <= shadow_d;
        end
    end

    assign avg_torque  = ops.torque;
    assign cadence_vec = ops.cadence;
    assign incline     = ops.incline;
    assign setting     = ops.setting;
    assign target_curr = tgt;
    assign upd_done    = upd;
    assign busy        = busy_q;

endmodule

// File: tb/tb_assist_seq.sv
// Self-checking bench for assist_seq: per-cycle scoreboard of target_curr,
// upd_done, busy and held torque, plus inline checks for reset and brake.
module tb_assist_seq;

    localparam int PIPE_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        brake_n = 1'b1;
    logic [11:0] avg_torque_in = '0;
    logic [4:0]  cadence_vec_in = '0;
    logic [12:0] incline_in = '0;
    logic [1:0]  setting_in = '0;
    logic [11:0] dd_target_curr = '0;
    logic [11:0] avg_torque;
    logic [4:0]  cadence_vec;
    logic [12:0] incline;
    logic [1:0]  setting;
    logic [11:0] target_curr;
    logic        upd_done;
    logic        busy;

    typedef struct {
        logic [11:0] tgt;
        logic        upd;
        logic        busy;
        logic [11:0] torque;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    assist_seq #(.PIPE_LAT(PIPE_LAT), .SLEW_STEP(12'h040)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .brake_n        (brake_n),
        .avg_torque_in  (avg_torque_in),
        .cadence_vec_in (cadence_vec_in),
        .incline_in     (incline_in),
        .setting_in     (setting_in),
        .avg_torque     (avg_torque),
        .cadence_vec    (cadence_vec),
        .incline        (incline),
        .setting        (setting),
        .dd_target_curr (dd_target_curr),
        .target_curr    (target_curr),
        .upd_done       (upd_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: one expected entry per clock, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks += 4;
            if (target_curr !== mon_e.tgt) begin
                errors++;
                $display("FAIL sb_target_curr: got %h expected %h at %0t", target_curr, mon_e.tgt, $time);
            end
            if (upd_done !== mon_e.upd) begin
                errors++;
                $display("FAIL sb_upd_done: got %b expected %b at %0t", upd_done, mon_e.upd, $time);
            end
            if (busy !== mon_e.busy) begin
                errors++;
                $display("FAIL sb_busy: got %b expected %b at %0t", busy, mon_e.busy, $time);
            end
            if (avg_torque !== mon_e.torque) begin
                errors++;
                $display("FAIL sb_avg_torque: got %h expected %h at %0t", avg_torque, mon_e.torque, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that samples the tick.
    task automatic do_tick(input logic [11:0] tq, input logic [4:0] cad,
                           input logic [12:0] inc, input logic [1:0] set);
        avg_torque_in  = tq;
        cadence_vec_in = cad;
        incline_in     = inc;
        setting_in     = set;
        tick           = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic push(input logic [11:0] tgt, input logic upd, input logic bsy,
                        input logic [11:0] tq);
        exp_t e;
        e.tgt    = tgt;
        e.upd    = upd;
        e.busy   = bsy;
        e.torque = tq;
        sb.push_back(e);
    endtask

    // Expected trace of one isolated update, starting after the tick edge.
    task automatic push_update(input logic [11:0] start, input logic [11:0] cap,
                               input logic [11:0] tq);
        logic [12:0] t;
        logic [12:0] nxt;
        t = {1'b0, start};
        for (int i = 0; i <= PIPE_LAT + 1; i++) push(t[11:0], 1'b0, 1'b1, tq);
        while (t[11:0] != cap) begin
            if (t[11:0] > cap) begin
                t = {1'b0, cap};
            end else begin
                nxt = t + 13'h040;
                t = (nxt > {1'b0, cap}) ? {1'b0, cap} : nxt;
            end
            push(t[11:0], 1'b0, 1'b1, tq);
        end
        push(t[11:0], 1'b1, 1'b0, tq);
        push(t[11:0], 1'b0, 1'b0, tq);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting} !== '0) begin
            errors++;
            $display("FAIL reset_held: outputs %h required 0",
                     {target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting} !== '0) begin
                errors++;
                $display("FAIL idle_cycle%0d: outputs %h required 0", i,
                         {target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting});
            end
        end
    endtask

    task automatic test_ramp_up();
        dd_target_curr = 12'h100;
        do_tick(12'h155, 5'h0A, 13'h1F00, 2'd2);
        push_update(12'h000, 12'h100, 12'h155);
        checks++;
        if ({cadence_vec, incline, setting} !== {5'h0A, 13'h1F00, 2'd2}) begin
            errors++;
            $display("FAIL ramp_operands: got %h required %h",
                     {cadence_vec, incline, setting}, {5'h0A, 13'h1F00, 2'd2});
        end
        avg_torque_in = 12'hEEE;
        wait_drain("ramp");
    endtask

    task automatic test_decrease();
        dd_target_curr = 12'h020;
        do_tick(12'h210, 5'h03, 13'h0010, 2'd1);
        push_update(12'h100, 12'h020, 12'h210);
        wait_drain("decrease");
    endtask

    task automatic test_saturation();
        dd_target_curr = 12'hFE0;
        do_tick(12'h300, 5'h04, 13'h0020, 2'd3);
        push_update(12'h020, 12'hFE0, 12'h300);
        wait_drain("climb_to_fe0");
        dd_target_curr = 12'hFFF;
        do_tick(12'h310, 5'h05, 13'h0030, 2'd3);
        push_update(12'hFE0, 12'hFFF, 12'h310);
        wait_drain("saturate");
    endtask

    task automatic test_pending();
        dd_target_curr = 12'h100;
        do_tick(12'h400, 5'h01, 13'h0001, 2'd1);
        for (int i = 0; i <= 5; i++) push(12'hFFF, 1'b0, 1'b1, 12'h400);
        push(12'h100, 1'b0, 1'b1, 12'h400);
        push(12'h100, 1'b1, 1'b1, 12'h700);
        for (int i = 0; i < 5; i++) push(12'h100, 1'b0, 1'b1, 12'h700);
        push(12'h100, 1'b1, 1'b0, 12'h700);
        push(12'h100, 1'b0, 1'b0, 12'h700);
        step();
        avg_torque_in = 12'h600;
        tick = 1'b1;
        step();
        avg_torque_in = 12'h700;
        step();
        tick = 1'b0;
        avg_torque_in = 12'h123;
        wait_drain("pending");
    endtask

    task automatic test_tick_at_completion();
        dd_target_curr = 12'h100;
        do_tick(12'h111, 5'h02, 13'h0002, 2'd0);
        for (int i = 0; i <= 5; i++) push(12'h100, 1'b0, 1'b1, 12'h111);
        push(12'h100, 1'b1, 1'b0, 12'h111);
        for (int i = 0; i <= 5; i++) push(12'h100, 1'b0, 1'b1, 12'h222);
        push(12'h100, 1'b1, 1'b0, 12'h222);
        push(12'h100, 1'b0, 1'b0, 12'h222);
        repeat (5) step();
        avg_torque_in = 12'h222;
        tick = 1'b1;
        step();
        tick = 1'b0;
        avg_torque_in = 12'h333;
        wait_drain("tick_at_completion");
    endtask

    task automatic test_brake();
        brake_n = 1'b0;
        step();
        brake_n = 1'b1;
        checks++;
        if (target_curr !== 12'h000) begin
            errors++;
            $display("FAIL brake_idle_zero: target_curr %h required 000", target_curr);
        end
        dd_target_curr = 12'h200;
        do_tick(12'h0AA, 5'h06, 13'h0040, 2'd2);
        for (int i = 0; i <= 5; i++) push(12'h000, 1'b0, 1'b1, 12'h0AA);
        push(12'h040, 1'b0, 1'b1, 12'h0AA);
        push(12'h080, 1'b0, 1'b1, 12'h0AA);
        push(12'h0C0, 1'b0, 1'b1, 12'h0AA);
        step();
        avg_torque_in = 12'h0BB;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (6) step();
        brake_n = 1'b0;
        step();
        checks++;
        if ({target_curr, busy, upd_done} !== {12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL brake_mid_slew: tgt/busy/upd %h required 0", {target_curr, busy, upd_done});
        end
        checks++;
        if (avg_torque !== 12'h0AA) begin
            errors++;
            $display("FAIL brake_operand_hold: avg_torque %h required 0AA", avg_torque);
        end
        avg_torque_in = 12'h0CC;
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL brake_tick_ignored: busy %b required 0", busy);
        end
        brake_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({target_curr, busy, upd_done} !== {12'h000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL brake_release_cycle%0d: tgt/busy/upd %h required 0", i,
                         {target_curr, busy, upd_done});
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL brake_sb_leftover: %0d entries required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_slew();
        dd_target_curr = 12'h300;
        do_tick(12'h0DD, 5'h07, 13'h0050, 2'd1);
        repeat (7) step();
        checks++;
        if ({target_curr, busy} !== {12'h080, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_slew: tgt/busy %h required %h", {target_curr, busy}, {12'h080, 1'b1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs %h required 0",
                     {target_curr, upd_done, busy, avg_torque, cadence_vec, incline, setting});
        end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({target_curr, busy} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: tgt/busy %h required 0", {target_curr, busy});
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_decrease();
        test_saturation();
        test_pending();
        test_tick_at_completion();
        test_brake();
        test_reset_mid_slew();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
